tlc_param_ctrl: RTL and testbench

TLC_PARAM_CTRL -- requirements
Module: tlc_param_ctrl

---
 rtl/tlc_param_ctrl.sv | 133 +++++++++++++
 tb/tb_tlc_param_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tlc_param_ctrl.sv
// tlc_param_ctrl -- two-road (highway / farm) traffic light controller with
// parameterised dwell times.
//
// Optional feature macro: TLC_SENSOR_EN
//   undefined : fixed timing, FarmSensor is ignored.
//   defined   : highway green is held until a farm vehicle is present, and
//               farm green ends early once the farm road is empty (bounded
//               by T_FARM_MAX).
//
// Ports
//   Clk           in   clock
//   Rst           in   synchronous active-high reset
//   FarmSensor    in   farm-road vehicle present (synchronous to Clk)
//   state         out  [2:0] current state (debug)
//   highwaySignal out  [1:0] highway lamp: 11 green, 10 yellow, 00 red
//   farmSignal    out  [1:0] farm lamp, same encoding
//   dwell         out  [CNT_W-1:0] cycles spent in the current state (debug)
module tlc_param_ctrl #(
    parameter int TICKS_PER_SEC = 50000000,
    parameter int T_ALLRED      = 1,
    parameter int T_HWY_GREEN   = 30,
    parameter int T_YELLOW      = 3,
    parameter int T_FARM_GREEN  = 15,
    parameter int T_FARM_MAX    = 30,
    parameter int CNT_W         = 32
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             FarmSensor,
    output logic [2:0]       state,
    output logic [1:0]       highwaySignal,
    output logic [1:0]       farmSignal,
    output logic [CNT_W-1:0] dwell
);

    typedef enum logic [2:0] {
        S0 = 3'd0,  // all red
        S1 = 3'd1,  // highway green
        S2 = 3'd2,  // highway yellow
        S3 = 3'd3,  // all red
        S4 = 3'd4,  // farm green
        S5 = 3'd5   // farm yellow
    } state_t;

    localparam logic [1:0] LAMP_GREEN  = 2'b11;
    localparam logic [1:0] LAMP_YELLOW = 2'b10;
    localparam logic [1:0] LAMP_RED    = 2'b00;

    // Last dwell value of each state: a D-second state is occupied for
    // exactly D*TICKS_PER_SEC cycles.
    localparam logic [CNT_W-1:0] LIM_ALLRED = CNT_W'(T_ALLRED * TICKS_PER_SEC - 1);
    localparam logic [CNT_W-1:0] LIM_HWY    = CNT_W'(T_HWY_GREEN * TICKS_PER_SEC - 1);
    localparam logic [CNT_W-1:0] LIM_YELLOW = CNT_W'(T_YELLOW * TICKS_PER_SEC - 1);
    localparam logic [CNT_W-1:0] LIM_FARM   = CNT_W'(T_FARM_GREEN * TICKS_PER_SEC - 1);

`ifdef TLC_SENSOR_EN
    localparam logic [CNT_W-1:0] LIM_FMAX   = CNT_W'(T_FARM_MAX * TICKS_PER_SEC - 1);
`else
    // Sensor path is compiled out; keep these inputs visibly consumed.
    logic             unused_sensor;
    logic [CNT_W-1:0] unused_fmax;
    assign unused_sensor = FarmSensor;
    assign unused_fmax   = CNT_W'(T_FARM_MAX * TICKS_PER_SEC - 1);
`endif

    // Plain vector register so the illegal codes 6/7 are representable.
    logic [2:0]       cur_state;
    logic [2:0]       next_state;
    logic [CNT_W-1:0] dwell_r;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}})
            return v;
        return v + 1'b1;
    endfunction

    always_ff @(posedge Clk) begin
        if (Rst)
            cur_state <= S0;
        else
            cur_state <= next_state;
    end

    // Counter restarts on the entry cycle of every new state.
    always_ff @(posedge Clk) begin
        if (Rst)
            dwell_r <= '0;
        else if (next_state != cur_state)
            dwell_r <= '0;
        else
            dwell_r <= sat_inc(dwell_r);
    end

    always_comb begin
        next_state = cur_state;
        case (cur_state)
            S0: if (dwell_r == LIM_ALLRED) next_state = S1;
`ifdef TLC_SENSOR_EN
            S1: if (dwell_r >= LIM_HWY && FarmSensor) next_state = S2;
`else
            S1: if (dwell_r == LIM_HWY) next_state = S2;
`endif
            S2: if (dwell_r == LIM_YELLOW) next_state = S3;
            S3: if (dwell_r == LIM_ALLRED) next_state = S4;
`ifdef TLC_SENSOR_EN
            S4: if ((dwell_r >= LIM_FARM && !FarmSensor) || dwell_r == LIM_FMAX)
                    next_state = S5;
`else
            S4: if (dwell_r == LIM_FARM) next_state = S5;
`endif
            S5: if (dwell_r == LIM_YELLOW) next_state = S0;
            default: next_state = S0;
        endcase
    end

    // Lamps depend on the state register alone, so at most one road is lit.
    always_comb begin
        highwaySignal = LAMP_RED;
        farmSignal    = LAMP_RED;
        case (cur_state)
            S1:      highwaySignal = LAMP_GREEN;
            S2:      highwaySignal = LAMP_YELLOW;
            S4:      farmSignal    = LAMP_GREEN;
            S5:      farmSignal    = LAMP_YELLOW;
            default: ;
        endcase
    end

    assign state = cur_state;
    assign dwell = dwell_r;

endmodule

// File: tb/tb_tlc_param_ctrl.sv
// tb_tlc_param_ctrl -- directed self-checking bench for tlc_param_ctrl with
// TICKS_PER_SEC=4 (other parameters default). Expected dwell lengths in
// cycles: S0 4, S1 120, S2 12, S3 4, S4 60, S5 12; farm maximum 120.
module tb_tlc_param_ctrl;

    localparam int CNT_W = 32;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             FarmSensor;
    logic [2:0]       state;
    logic [1:0]       highwaySignal;
    logic [1:0]       farmSignal;
    logic [CNT_W-1:0] dwell;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    tlc_param_ctrl #(
        .TICKS_PER_SEC(4),
        .CNT_W        (CNT_W)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .FarmSensor   (FarmSensor),
        .state        (state),
        .highwaySignal(highwaySignal),
        .farmSignal   (farmSignal),
        .dwell        (dwell)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Every sampled cycle: the two roads are never lit together.
    always @(negedge Clk) begin
        if (mon_en)
            chk("lamp_mutex", {63'd0, (highwaySignal != 2'b00) && (farmSignal != 2'b00)}, 64'd0);
    end

    // Called at a negedge where the state should just have been entered.
    // Counts the samples spent in it; a loop bound keeps a stuck DUT finite.
    task automatic run_state(input string tag, input logic [2:0] st,
                             input logic [1:0] hw, input logic [1:0] fm, input int len);
        int n = 0;
        chk({tag, "_state"}, state, st);
        chk({tag, "_dwell0"}, dwell, 0);
        chk({tag, "_hwy"}, highwaySignal, hw);
        chk({tag, "_farm"}, farmSignal, fm);
        while (state == st && n < len + 10) begin
            n++;
            @(negedge Clk);
        end
        chk({tag, "_len"}, n, len);
    endtask

    task automatic run_s0_to_s3(input string tag);
        run_state({tag, "_s0"}, 3'd0, 2'b00, 2'b00, 4);
        run_state({tag, "_s1"}, 3'd1, 2'b11, 2'b00, 120);
        run_state({tag, "_s2"}, 3'd2, 2'b10, 2'b00, 12);
        run_state({tag, "_s3"}, 3'd3, 2'b00, 2'b00, 4);
    endtask

    task automatic run_full(input string tag);
        run_s0_to_s3(tag);
        run_state({tag, "_s4"}, 3'd4, 2'b00, 2'b11, 60);
        run_state({tag, "_s5"}, 3'd5, 2'b00, 2'b10, 12);
        chk({tag, "_wrap"}, state, 3'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, state, 3'd0);
        chk({tag, "_dwell"}, dwell, 0);
        chk({tag, "_hwy"}, highwaySignal, 2'b00);
        chk({tag, "_farm"}, farmSignal, 2'b00);
    endtask

    task automatic pulse_reset(input string tag);
        Rst = 1'b1;
        @(negedge Clk);
        chk_reset(tag);
        Rst = 1'b0;
    endtask

    initial begin
        Rst        = 1'b1;
        FarmSensor = 1'b0;
        repeat (2) @(negedge Clk);
        mon_en = 1'b1;
        chk_reset("por");
        Rst = 1'b0;

`ifndef TLC_SENSOR_EN
        // Fixed timing sequence.
        run_full("fix");

        // Sensor toggled on must change nothing; reset mid farm green.
        FarmSensor = 1'b1;
        run_s0_to_s3("ign");
        chk("ign_s4_entry", state, 3'd4);
        repeat (17) @(negedge Clk);
        chk("mid_s4_state", state, 3'd4);
        chk("mid_s4_dwell", dwell, 17);
        pulse_reset("rst_s4");
        run_full("rst_seq");
        FarmSensor = 1'b0;
`else
        // Highway green held while no farm vehicle is waiting.
        run_state("sen_s0", 3'd0, 2'b00, 2'b00, 4);
        chk("hold_s1_entry", state, 3'd1);
        repeat (400) @(negedge Clk);
        chk("hold_s1_state", state, 3'd1);
        chk("hold_s1_dwell", dwell, 400);

        // Vehicle arrives at S1 dwell 200.
        pulse_reset("rst_sen");
        run_state("arr_s0", 3'd0, 2'b00, 2'b00, 4);
        repeat (200) @(negedge Clk);
        chk("arr_s1_dwell", dwell, 200);
        FarmSensor = 1'b1;
        @(negedge Clk);
        chk("arr_exit_s2", state, 3'd2);

        // Sensor held: farm green runs to its maximum, highway green to its minimum.
        run_state("hold_s2", 3'd2, 2'b10, 2'b00, 12);
        run_state("hold_s3", 3'd3, 2'b00, 2'b00, 4);
        run_state("fmax_s4", 3'd4, 2'b00, 2'b11, 120);
        run_state("fmax_s5", 3'd5, 2'b00, 2'b10, 12);
        run_s0_to_s3("min");

        // Farm road empties at S4 dwell 70.
        chk("drop_s4_entry", state, 3'd4);
        repeat (70) @(negedge Clk);
        chk("drop_s4_dwell", dwell, 70);
        FarmSensor = 1'b0;
        @(negedge Clk);
        chk("drop_exit_s5", state, 3'd5);
`endif

        // Illegal state code recovers to S0 with all lamps red.
        pulse_reset("rst_ill");
        run_state("ill_s0", 3'd0, 2'b00, 2'b00, 4);
        repeat (5) @(negedge Clk);
        force dut.cur_state = 3'd7;
        #1;
        chk("ill_state", state, 3'd7);
        chk("ill_hwy", highwaySignal, 2'b00);
        chk("ill_farm", farmSignal, 2'b00);
        release dut.cur_state;
        @(negedge Clk);
        chk("ill_recover", state, 3'd0);
        run_state("ill_after", 3'd0, 2'b00, 2'b00, 4);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
